aer_out_fifo_enc: RTL

Parametrised successor to the single-register AER output encoder. It accepts pixel/neuron addresses from the sorter through a valid/ready interface and buffers them in an internal FIFO. It drains them over an asynchronous 4-phase AER link, with a configurable ACK synchroniser depth, an optional REQ timeout with a sticky error flag, and status counters. It sits between the sorter and the off-chip/core AER input link.

---
 rtl/aer_pkg.sv | 16 +
 rtl/aer_addr_fifo.sv | 55 +++++
 rtl/aer_out_fifo_enc.sv | 132 +++++++++++++
 3 files changed

// File: rtl/aer_pkg.sv
// Shared types for the buffered AER output encoder.
// Holds the handshake FSM state encoding and the FIFO level width helper.
package aer_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      REQ     = 2'd1,
      ACK_LOW = 2'd2
   } aer_state_t;

   // Occupancy must represent 0..depth inclusive.
   function automatic int lvl_w(input int depth);
      return $clog2(depth) + 1;
   endfunction

endpackage

// File: rtl/aer_addr_fifo.sv
// Synchronous address FIFO with flush; pointers carry a wrap bit.
// Ports: CLK, RST, push/push_data, pop, flush -> head, full, empty, level.
module aer_addr_fifo
   import aer_pkg::*;
#(
   parameter int ADDR_W = 8,
   parameter int DEPTH  = 8
)(
   input  logic                    CLK,
   input  logic                    RST,
   input  logic                    push,
   input  logic [ADDR_W-1:0]       push_data,
   input  logic                    pop,
   input  logic                    flush,
   output logic [ADDR_W-1:0]       head,
   output logic                    full,
   output logic                    empty,
   output logic [lvl_w(DEPTH)-1:0] level
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] ONE = (AW+1)'(1);
   localparam logic [AW:0] WRAP = {1'b1, {AW{1'b0}}};

   logic [AW:0]       wr_ptr;
   logic [AW:0]       rd_ptr;
   logic [ADDR_W-1:0] mem [DEPTH];
   logic              do_push;
   logic              do_pop;

   assign full    = (wr_ptr ^ rd_ptr) == WRAP;
   assign empty   = wr_ptr == rd_ptr;
   assign level   = wr_ptr - rd_ptr;
   assign head    = mem[rd_ptr[AW-1:0]];
   // Flush wins over both a push and a pop in the same cycle.
   assign do_push = push & ~full & ~flush;
   assign do_pop  = pop & ~empty & ~flush;

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else if (flush) begin
         rd_ptr <= wr_ptr;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + ONE;
         if (do_pop)  rd_ptr <= rd_ptr + ONE;
      end
   end

   always_ff @(posedge CLK) begin
      if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
   end

endmodule

// File: rtl/aer_out_fifo_enc.sv
// Buffered AER output encoder: FIFO in front of a 4-phase REQ/ACK link.
// Ports: CLK, RST, EVT_* sorter side, FLUSH, CLR_ERR, AERIN_* link, status.
module aer_out_fifo_enc
   import aer_pkg::*;
#(
   parameter int ADDR_W         = 8,
   parameter int DEPTH          = 8,
   parameter int SYNC_STAGES    = 2,
   parameter int TIMEOUT_CYCLES = 1024,
   parameter int CNT_W          = 16
)(
   input  logic                    CLK,
   input  logic                    RST,
   input  logic [ADDR_W-1:0]       EVT_ADDR,
   input  logic                    EVT_VALID,
   output logic                    EVT_READY,
   input  logic                    FLUSH,
   input  logic                    CLR_ERR,
   output logic [ADDR_W-1:0]       AERIN_ADDR,
   output logic                    AERIN_REQ,
   input  logic                    AERIN_ACK,
   output logic                    AERIN_CTRL_BUSY,
   output logic [lvl_w(DEPTH)-1:0] FIFO_LEVEL,
   output logic [CNT_W-1:0]        EVT_SENT_CNT,
   output logic                    TIMEOUT_ERR
);

   localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [TW-1:0] T_LAST =
      TW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
   localparam bit TO_EN = TIMEOUT_CYCLES != 0;

   aer_state_t             state_q, state_d;
   logic [SYNC_STAGES-1:0] ack_sync;
   logic                   ack_s;
   logic [ADDR_W-1:0]      head;
   logic                   full, empty, pop;
   logic                   req_d, abort_q, abort_d, err_d;
   logic [ADDR_W-1:0]      addr_d;
   logic [TW-1:0]          timer_q, timer_d;
   logic [CNT_W-1:0]       cnt_d;

   aer_addr_fifo #(
      .ADDR_W (ADDR_W),
      .DEPTH  (DEPTH)
   ) u_fifo (
      .CLK       (CLK),
      .RST       (RST),
      .push      (EVT_VALID),
      .push_data (EVT_ADDR),
      .pop       (pop),
      .flush     (FLUSH),
      .head      (head),
      .full      (full),
      .empty     (empty),
      .level     (FIFO_LEVEL)
   );

   assign EVT_READY       = ~full;
   assign ack_s           = ack_sync[SYNC_STAGES-1];
   assign AERIN_CTRL_BUSY = (state_q != IDLE) | (FIFO_LEVEL != '0);

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) state_q <= IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      req_d   = AERIN_REQ;
      addr_d  = AERIN_ADDR;
      timer_d = timer_q;
      abort_d = abort_q;
      cnt_d   = EVT_SENT_CNT;
      err_d   = CLR_ERR ? 1'b0 : TIMEOUT_ERR;
      pop     = 1'b0;
      unique case (state_q)
         IDLE: begin
            // A still-high ACK from a previous cycle blocks the next REQ.
            if (~empty & ~ack_s & ~FLUSH) begin
               pop     = 1'b1;
               addr_d  = head;
               req_d   = 1'b1;
               timer_d = '0;
               abort_d = 1'b0;
               state_d = REQ;
            end
         end
         REQ: begin
            if (ack_s) begin
               req_d   = 1'b0;
               state_d = ACK_LOW;
            end else if (TO_EN && timer_q == T_LAST) begin
               req_d   = 1'b0;
               err_d   = 1'b1;
               abort_d = 1'b1;
               state_d = ACK_LOW;
            end else begin
               timer_d = timer_q + TW'(1);
            end
         end
         ACK_LOW: begin
            if (~ack_s) begin
               state_d = IDLE;
               if (~abort_q) cnt_d = EVT_SENT_CNT + CNT_W'(1);
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         ack_sync     <= '0;
         AERIN_REQ    <= 1'b0;
         AERIN_ADDR   <= '0;
         timer_q      <= '0;
         abort_q      <= 1'b0;
         EVT_SENT_CNT <= '0;
         TIMEOUT_ERR  <= 1'b0;
      end else begin
         ack_sync     <= {ack_sync[SYNC_STAGES-2:0], AERIN_ACK};
         AERIN_REQ    <= req_d;
         AERIN_ADDR   <= addr_d;
         timer_q      <= timer_d;
         abort_q      <= abort_d;
         EVT_SENT_CNT <= cnt_d;
         TIMEOUT_ERR  <= err_d;
      end
   end

endmodule
